// File: rtl/cache_fill_pkg.sv
// Shared types and geometry helpers for the cache line fill engine.
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } fill_side_e;

  function automatic int word_bytes(input int word_w);
    return word_w / 8;
  endfunction

  function automatic int line_bytes(input int word_w, input int line_words);
    return (word_w / 8) * line_words;
  endfunction

  function automatic int ofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_fill_arbiter.sv
// Two-way round-robin grant between I and D fill requests; priority flips on each completed fill.
module cache_fill_arbiter
  import cache_fill_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req_i,
  input  logic       i_req_d,
  input  logic       i_update,
  input  fill_side_e i_served,
  output logic       o_gnt_valid,
  output fill_side_e o_gnt_side
);

  // r_prio is the side that wins when both request at once.
  fill_side_e r_prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= SIDE_D;
    end else if (i_update) begin
      r_prio <= (i_served == SIDE_I) ? SIDE_D : SIDE_I;
    end
  end

  always_comb begin
    o_gnt_valid = i_req_i || i_req_d;
    o_gnt_side  = SIDE_I;
    if (i_req_i && i_req_d) begin
      o_gnt_side = r_prio;
    end else if (i_req_d) begin
      o_gnt_side = SIDE_D;
    end
  end

endmodule

// File: rtl/cache_line_fill_engine.sv
// Cache line fill engine: arbitrates I/D misses, fetches a line critical-word-first
// from the SDRAM controller in burst or single-beat mode, and presents the assembled line.
module cache_line_fill_engine
  import cache_fill_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter int CWF        = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_fill_req,
  input  logic [ADDR_W-1:0]              i_fill_addr,
  input  logic                           i_burst_en,
  input  logic                           d_fill_req,
  input  logic [ADDR_W-1:0]              d_fill_addr,
  input  logic                           d_burst_en,
  input  logic                           abort,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_burst,
  output logic [$clog2(LINE_WORDS)-1:0]  mem_burst_len,
  input  logic [WORD_W-1:0]              mem_data,
  input  logic                           mem_ack,
  output logic [LINE_WORDS*WORD_W-1:0]   fill_data,
  output logic [ADDR_W-1:0]              fill_addr,
  output logic                           fill_valid_i,
  output logic                           fill_valid_d,
  output logic                           busy,
  output logic                           err,
  output fill_state_e                    o_dbg_state
);

  localparam int WORD_BYTES = word_bytes(WORD_W);
  localparam int LINE_BYTES = line_bytes(WORD_W, LINE_WORDS);
  localparam int OFS_W      = ofs_w(LINE_WORDS);
  localparam int WB_W       = $clog2(WORD_BYTES);
  localparam int TMO_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  fill_state_e              r_state;
  fill_side_e               r_side;
  logic [ADDR_W-1:0]        r_base;
  logic [OFS_W-1:0]         r_idx0;
  logic [OFS_W-1:0]         r_beat;
  logic                     r_burst;
  logic [TMO_W-1:0]         r_tmo;
  logic [LINE_WORDS*WORD_W-1:0] r_line;

  fill_state_e              w_next;
  logic                     w_gnt_valid;
  fill_side_e               w_gnt_side;
  logic [ADDR_W-1:0]        w_gnt_addr;
  logic [ADDR_W-1:0]        w_gnt_base;
  logic [OFS_W-1:0]         w_gnt_idx;
  logic                     w_gnt_burst;
  logic                     w_active;
  logic                     w_ack;
  logic                     w_last;
  logic                     w_tmo;
  logic                     w_done;
  logic [OFS_W-1:0]         w_slot;
  logic [ADDR_W-1:0]        w_start_addr;
  logic [ADDR_W-1:0]        w_slot_addr;

  cache_fill_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req_i     (i_fill_req),
    .i_req_d     (d_fill_req),
    .i_update    (w_done),
    .i_served    (r_side),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_side  (w_gnt_side)
  );

  assign w_gnt_addr   = (w_gnt_side == SIDE_I) ? i_fill_addr : d_fill_addr;
  assign w_gnt_burst  = (w_gnt_side == SIDE_I) ? i_burst_en  : d_burst_en;
  assign w_gnt_base   = w_gnt_addr & ~LINE_MASK;
  assign w_gnt_idx    = OFS_W'((w_gnt_addr & LINE_MASK) >> WB_W);

  // Slot index wraps mod LINE_WORDS through natural OFS_W-bit overflow.
  assign w_slot       = r_idx0 + r_beat;
  assign w_start_addr = r_base + ADDR_W'(r_idx0) * ADDR_W'(WORD_BYTES);
  assign w_slot_addr  = r_base + ADDR_W'(w_slot) * ADDR_W'(WORD_BYTES);

  // Memory handshake: mem_req stays high from grant until the final beat; each cycle
  // with mem_ack high while requesting transfers exactly one word on mem_data.
  assign w_active = (r_state == REQ) || (r_state == FILL);
  assign w_ack    = w_active && mem_ack;
  assign w_last   = (r_beat == OFS_W'(LINE_WORDS - 1));
  assign w_tmo    = (TIMEOUT != 0) && w_active && !mem_ack && (r_tmo == TMO_W'(TIMEOUT));
  assign w_done   = (r_state == DONE) && !abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_gnt_valid) w_next = REQ;
      REQ, FILL: begin
        if (w_ack) begin
          w_next = w_last ? DONE : FILL;
        end else if (w_tmo) begin
          w_next = IDLE;
        end
      end
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (abort) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_side  <= SIDE_I;
      r_base  <= '0;
      r_idx0  <= '0;
      r_beat  <= '0;
      r_burst <= 1'b0;
      r_tmo   <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_gnt_valid && !abort) begin
        r_side  <= w_gnt_side;
        r_base  <= w_gnt_base;
        r_idx0  <= (CWF != 0) ? w_gnt_idx : '0;
        r_burst <= w_gnt_burst;
        r_beat  <= '0;
        r_tmo   <= '0;
      end else if (w_ack && !abort) begin
        r_line[w_slot*WORD_W +: WORD_W] <= mem_data;
        r_beat <= r_beat + 1'b1;
        r_tmo  <= '0;
      end else if (w_active && (TIMEOUT != 0)) begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign mem_req       = w_active;
  assign mem_burst     = w_active && r_burst;
  assign mem_burst_len = w_active ? OFS_W'(LINE_WORDS - 1) : '0;
  assign mem_addr      = !w_active ? '0 : (r_burst ? w_start_addr : w_slot_addr);
  assign fill_data     = r_line;
  assign fill_addr     = r_base;
  assign fill_valid_i  = w_done && (r_side == SIDE_I);
  assign fill_valid_d  = w_done && (r_side == SIDE_D);
  assign busy          = (r_state != IDLE);
  assign err           = w_tmo;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cache_line_fill_engine.sv
// Directed bench for cache_line_fill_engine: default instance for ordering/arbitration/abort,
// a 32-bit/4-word/no-CWF/TIMEOUT=4 instance for timeout and geometry.
module tb_cache_line_fill_engine;
  import cache_fill_pkg::*;

  logic          clk;
  logic          reset;

  logic          i_fill_req, d_fill_req, i_burst_en, d_burst_en, abort, mem_ack;
  logic [31:0]   i_fill_addr, d_fill_addr, mem_addr, fill_addr;
  logic          mem_req, mem_burst, fill_valid_i, fill_valid_d, busy, err;
  logic [2:0]    mem_burst_len;
  logic [15:0]   mem_data;
  logic [127:0]  fill_data;
  fill_state_e   dbg_state;

  logic          b_i_fill_req, b_d_fill_req, b_i_burst_en, b_d_burst_en, b_abort, b_mem_ack;
  logic [31:0]   b_i_fill_addr, b_d_fill_addr, b_mem_addr, b_fill_addr;
  logic          b_mem_req, b_mem_burst, b_fill_valid_i, b_fill_valid_d, b_busy, b_err;
  logic [1:0]    b_mem_burst_len;
  logic [31:0]   b_mem_data;
  logic [127:0]  b_fill_data;
  fill_state_e   b_dbg_state;

  logic [31:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  cache_line_fill_engine u_dut (
    .clk(clk), .reset(reset),
    .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr), .i_burst_en(i_burst_en),
    .d_fill_req(d_fill_req), .d_fill_addr(d_fill_addr), .d_burst_en(d_burst_en),
    .abort(abort), .mem_req(mem_req), .mem_addr(mem_addr), .mem_burst(mem_burst),
    .mem_burst_len(mem_burst_len), .mem_data(mem_data), .mem_ack(mem_ack),
    .fill_data(fill_data), .fill_addr(fill_addr), .fill_valid_i(fill_valid_i),
    .fill_valid_d(fill_valid_d), .busy(busy), .err(err), .o_dbg_state(dbg_state)
  );

  cache_line_fill_engine #(
    .WORD_W(32), .LINE_WORDS(4), .ADDR_W(32), .CWF(0), .TIMEOUT(4)
  ) u_dut_b (
    .clk(clk), .reset(reset),
    .i_fill_req(b_i_fill_req), .i_fill_addr(b_i_fill_addr), .i_burst_en(b_i_burst_en),
    .d_fill_req(b_d_fill_req), .d_fill_addr(b_d_fill_addr), .d_burst_en(b_d_burst_en),
    .abort(b_abort), .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_burst(b_mem_burst),
    .mem_burst_len(b_mem_burst_len), .mem_data(b_mem_data), .mem_ack(b_mem_ack),
    .fill_data(b_fill_data), .fill_addr(b_fill_addr), .fill_valid_i(b_fill_valid_i),
    .fill_valid_d(b_fill_valid_d), .busy(b_busy), .err(b_err), .o_dbg_state(b_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks for the default instance
  task automatic wait_grant(input int exp_wait);
    int w;
    w = 0;
    while (!mem_req && w < 16) begin
      tick();
      w++;
    end
    check_eq("grant_seen", mem_req, 1'b1);
    check_eq("grant_state", dbg_state, REQ);
    if (exp_wait > 0) check_eq("grant_latency", w, exp_wait);
  endtask

  task automatic do_beat(input logic [15:0] data);
    logic [31:0] ea;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 1'b1, 1'b0);
      ea = '0;
    end else begin
      ea = exp_q.pop_front();
    end
    check_eq("mem_addr", mem_addr, ea);
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
  endtask

  task automatic run_fill(input bit is_d, input logic [31:0] addr, input bit burst,
                          input logic [15:0] dbase, input logic [31:0] exp_base,
                          input logic [127:0] exp_data, input int exp_wait);
    if (is_d) begin
      d_fill_req = 1'b1; d_fill_addr = addr; d_burst_en = burst;
    end else begin
      i_fill_req = 1'b1; i_fill_addr = addr; i_burst_en = burst;
    end
    wait_grant(exp_wait);
    check_eq("mem_burst", mem_burst, burst);
    check_eq("burst_len", mem_burst_len, 3'd7);
    for (int n = 0; n < 8; n++) begin
      do_beat(dbase + 16'(n));
    end
    check_eq("valid_i", fill_valid_i, !is_d);
    check_eq("valid_d", fill_valid_d, is_d);
    check_eq("req_after_last", mem_req, 1'b0);
    check_eq("fill_addr", fill_addr, exp_base);
    check_eq("fill_data", fill_data, exp_data);
    check_eq("sb_drain", exp_q.size(), 0);
    if (is_d) d_fill_req = 1'b0;
    else      i_fill_req = 1'b0;
  endtask

  task automatic check_idle_after();
    tick();
    check_eq("pulse_len_i", fill_valid_i, 1'b0);
    check_eq("pulse_len_d", fill_valid_d, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0; mem_ack = 1'b0; mem_data = '0;
    i_fill_req = 1'b0; d_fill_req = 1'b0; i_burst_en = 1'b0; d_burst_en = 1'b0;
    i_fill_addr = '0; d_fill_addr = '0;
    b_abort = 1'b0; b_mem_ack = 1'b0; b_mem_data = '0;
    b_i_fill_req = 1'b0; b_d_fill_req = 1'b0; b_i_burst_en = 1'b0; b_d_burst_en = 1'b0;
    b_i_fill_addr = '0; b_d_fill_addr = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_burst", {mem_burst, mem_burst_len}, 4'h0);
    check_eq("rst_fill_data", fill_data, 128'h0);
    check_eq("rst_fill_addr", fill_addr, 32'h0);
    check_eq("rst_valids", {fill_valid_i, fill_valid_d, busy, err}, 4'h0);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_b_outs", {b_mem_req, b_busy, b_err, b_fill_valid_i, b_fill_valid_d}, 5'h0);

    // Simultaneous pair from reset: D first, then I
    i_fill_req = 1'b1; i_fill_addr = 32'h4012; i_burst_en = 1'b1;
    for (int n = 0; n < 8; n++) exp_q.push_back(32'h3000 + 32'(2 * n));
    run_fill(1'b1, 32'h3000, 1'b0, 16'hC000, 32'h3000,
             128'hC007_C006_C005_C004_C003_C002_C001_C000, 1);
    for (int n = 0; n < 8; n++) exp_q.push_back(32'h4012);
    run_fill(1'b0, 32'h4012, 1'b1, 16'hD000, 32'h4010,
             128'hD006_D005_D004_D003_D002_D001_D000_D007, 2);
    check_idle_after();

    // Single-beat D fill, critical word first at 0x1006
    exp_q = '{32'h1006, 32'h1008, 32'h100A, 32'h100C, 32'h100E, 32'h1000, 32'h1002, 32'h1004};
    run_fill(1'b1, 32'h1006, 1'b0, 16'hA000, 32'h1000,
             128'hA004_A003_A002_A001_A000_A007_A006_A005, 1);
    check_idle_after();

    // Second simultaneous pair after a D fill: I first, then D
    d_fill_req = 1'b1; d_fill_addr = 32'h7008; d_burst_en = 1'b1;
    for (int n = 0; n < 8; n++) exp_q.push_back(32'h6000 + 32'(2 * n));
    run_fill(1'b0, 32'h6000, 1'b0, 16'h1000, 32'h6000,
             128'h1007_1006_1005_1004_1003_1002_1001_1000, 1);
    for (int n = 0; n < 8; n++) exp_q.push_back(32'h7008);
    run_fill(1'b1, 32'h7008, 1'b1, 16'h2000, 32'h7000,
             128'h2003_2002_2001_2000_2007_2006_2005_2004, 2);
    check_idle_after();

    // Burst I fill at 0x2000, back-to-back acks
    for (int n = 0; n < 8; n++) exp_q.push_back(32'h2000);
    run_fill(1'b0, 32'h2000, 1'b1, 16'hB000, 32'h2000,
             128'hB007_B006_B005_B004_B003_B002_B001_B000, 1);
    check_idle_after();

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_data = 16'hFFFF;
    tick();
    mem_ack = 1'b0;
    check_eq("idle_ack_busy", busy, 1'b0);
    check_eq("idle_ack_data", fill_data, 128'hB007_B006_B005_B004_B003_B002_B001_B000);

    // Abort after the 4th ack; the request drop mid-fill is ignored until then
    exp_q = '{32'h8006, 32'h8008, 32'h800A, 32'h800C};
    d_fill_req = 1'b1; d_fill_addr = 32'h8006; d_burst_en = 1'b0;
    wait_grant(1);
    d_fill_req = 1'b0;
    for (int n = 0; n < 4; n++) do_beat(16'h4000 + 16'(n));
    check_eq("pre_abort_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_req", mem_req, 1'b0);
    check_eq("abort_valid", {fill_valid_i, fill_valid_d}, 2'b00);
    tick();
    check_eq("abort_valid_late", {fill_valid_i, fill_valid_d, busy}, 3'b000);
    exp_q = '{32'h900C, 32'h900E, 32'h9000, 32'h9002, 32'h9004, 32'h9006, 32'h9008, 32'h900A};
    run_fill(1'b0, 32'h900C, 1'b0, 16'h3000, 32'h9000,
             128'h3001_3000_3007_3006_3005_3004_3003_3002, 1);
    check_idle_after();

    // Timeout on the TIMEOUT=4 instance
    b_d_fill_req = 1'b1; b_d_fill_addr = 32'h200; b_d_burst_en = 1'b0;
    tick();
    b_d_fill_req = 1'b0;
    check_eq("b_grant", b_mem_req, 1'b1);
    begin
      int c;
      c = 0;
      while (!b_err && c < 10) begin
        tick();
        c++;
      end
      check_eq("tmo_cycles", c, 4);
    end
    check_eq("tmo_no_valid", {b_fill_valid_i, b_fill_valid_d}, 2'b00);
    tick();
    check_eq("tmo_idle", {b_busy, b_err, b_mem_req}, 3'b000);

    // 32-bit words, 4-word line, no CWF: 0x10C starts at 0x100
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    b_i_fill_req = 1'b1; b_i_fill_addr = 32'h10C; b_i_burst_en = 1'b0;
    tick();
    b_i_fill_req = 1'b0;
    check_eq("b_burst_len", b_mem_burst_len, 2'd3);
    for (int n = 0; n < 4; n++) begin
      check_eq("b_mem_addr", b_mem_addr, exp_q.pop_front());
      b_mem_ack = 1'b1;
      b_mem_data = 32'hF000_0000 + 32'(n);
      tick();
      b_mem_ack = 1'b0;
    end
    check_eq("b_valid_i", b_fill_valid_i, 1'b1);
    check_eq("b_fill_addr", b_fill_addr, 32'h100);
    check_eq("b_fill_data", b_fill_data, 128'hF0000003_F0000002_F0000001_F0000000);
    check_eq("b_no_err", b_err, 1'b0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
